// File: rtl/pwmservo_core.sv
// pwmservo_core: servo PWM generator with double-buffered config and per-period slew limit
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   cfg_enable           1 = generate PWM (0 returns to IDLE, abandoning the period)
//   cfg_period/pulse/step register values, captured into pending on cfg_update
//   cfg_update           one-cycle strobe after a register write
//   pwm_out              registered PWM waveform
//   period_tick          one-cycle pulse at each period wrap
//   cur_pulse            pulse width currently applied
//   busy                 1 while cur_pulse differs from the active target
module pwmservo_core #(
    parameter int C_CNT_WIDTH = 24
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   cfg_enable,
    input  logic [C_CNT_WIDTH-1:0] cfg_period,
    input  logic [C_CNT_WIDTH-1:0] cfg_pulse,
    input  logic [C_CNT_WIDTH-1:0] cfg_step,
    input  logic                   cfg_update,
    output logic                   pwm_out,
    output logic                   period_tick,
    output logic [C_CNT_WIDTH-1:0] cur_pulse,
    output logic                   busy
);
    localparam int W = C_CNT_WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] pend_period_q, pend_period_d, pend_pulse_q, pend_pulse_d, pend_step_q, pend_step_d;
    logic [W-1:0] act_period_q, act_period_d, act_pulse_q, act_pulse_d, act_step_q, act_step_d;
    logic [W-1:0] cur_q, cur_d;
    logic         pwm_q, pwm_d, tick_q, tick_d, busy_q, busy_d;

    logic [W:0]   up, dn;
    logic [W-1:0] ramp, last;
    logic         wrap;

    // Slew toward the target that becomes active at the boundary; the extra bit
    // catches overflow on the way up and underflow on the way down.
    assign up   = {1'b0, cur_q} + {1'b0, pend_step_q};
    assign dn   = {1'b0, cur_q} - {1'b0, pend_step_q};
    assign ramp = (pend_step_q == '0) ? pend_pulse_q :
                  (cur_q < pend_pulse_q) ? ((up > {1'b0, pend_pulse_q}) ? pend_pulse_q : up[W-1:0]) :
                  (dn[W] || (dn[W-1:0] < pend_pulse_q)) ? pend_pulse_q : dn[W-1:0];

    // Periods shorter than 2 cycles run as 2.
    assign last = (act_period_q < W'(2)) ? W'(1) : act_period_q - W'(1);
    assign wrap = cnt_q >= last;

    always_comb begin
        pend_period_d = cfg_update ? cfg_period : pend_period_q;
        pend_pulse_d  = cfg_update ? cfg_pulse  : pend_pulse_q;
        pend_step_d   = cfg_update ? cfg_step   : pend_step_q;
        state_d       = state_q;
        cnt_d         = '0;
        pwm_d         = 1'b0;
        tick_d        = 1'b0;
        act_period_d  = act_period_q;
        act_pulse_d   = act_pulse_q;
        act_step_d    = act_step_q;
        cur_d         = cur_q;
        if (state_q == IDLE) begin
            act_period_d = pend_period_q;
            act_pulse_d  = pend_pulse_q;
            act_step_d   = pend_step_q;
            cur_d        = pend_pulse_q;
            state_d      = cfg_enable ? RUN : IDLE;
        end else if (!cfg_enable) begin
            state_d = IDLE;
        end else begin
            pwm_d = cnt_q < cur_q;
            if (wrap) begin
                tick_d       = 1'b1;
                act_period_d = pend_period_q;
                act_pulse_d  = pend_pulse_q;
                act_step_d   = pend_step_q;
                cur_d        = ramp;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
        busy_d = cur_d != act_pulse_d;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pend_period_q <= '0;
            pend_pulse_q  <= '0;
            pend_step_q   <= '0;
            act_period_q  <= '0;
            act_pulse_q   <= '0;
            act_step_q    <= '0;
            cur_q         <= '0;
            pwm_q         <= 1'b0;
            tick_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_period_q <= pend_period_d;
            pend_pulse_q  <= pend_pulse_d;
            pend_step_q   <= pend_step_d;
            act_period_q  <= act_period_d;
            act_pulse_q   <= act_pulse_d;
            act_step_q    <= act_step_d;
            cur_q         <= cur_d;
            pwm_q         <= pwm_d;
            tick_q        <= tick_d;
            busy_q        <= busy_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;
    assign cur_pulse   = cur_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_pwmservo_core.sv
// tb_pwmservo_core: scoreboard of per-period {length, high count} plus scenario checks
module tb_pwmservo_core;
    localparam int W = 24;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic         cfg_enable = 1'b0;
    logic         cfg_update = 1'b0;
    logic [W-1:0] cfg_period = '0;
    logic [W-1:0] cfg_pulse = '0;
    logic [W-1:0] cfg_step = '0;
    logic         pwm_out, period_tick, busy;
    logic [W-1:0] cur_pulse;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int len;
        int hi;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic mon_en = 1'b0;
    int   mon_len = 0;
    int   mon_hi = 0;

    always #5 ACLK = ~ACLK;

    pwmservo_core #(.C_CNT_WIDTH(W)) dut (
        .ACLK(ACLK),
        .ARESETN(ARESETN),
        .cfg_enable(cfg_enable),
        .cfg_period(cfg_period),
        .cfg_pulse(cfg_pulse),
        .cfg_step(cfg_step),
        .cfg_update(cfg_update),
        .pwm_out(pwm_out),
        .period_tick(period_tick),
        .cur_pulse(cur_pulse),
        .busy(busy)
    );

    // Each tick closes a period: compare its length and high-time against the oldest expectation.
    always @(negedge ACLK) begin
        if (!mon_en || !ARESETN) begin
            mon_len = 0;
            mon_hi  = 0;
        end else begin
            mon_len++;
            if (pwm_out) mon_hi++;
            if (period_tick) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tick: got a tick, required none (len=%0d hi=%0d)", mon_len, mon_hi);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_len !== mon_e.len) begin
                        errors++;
                        $display("FAIL period_len: got %0d, required %0d", mon_len, mon_e.len);
                    end
                    checks++;
                    if (mon_hi !== mon_e.hi) begin
                        errors++;
                        $display("FAIL high_time: got %0d, required %0d", mon_hi, mon_e.hi);
                    end
                end
                mon_len = 0;
                mon_hi  = 0;
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(negedge ACLK);
            #1;
        end
    endtask

    task automatic push(int len, int hi);
        exp_t e;
        e.len = len;
        e.hi  = hi;
        sb.push_back(e);
    endtask

    task automatic update(int p, int pw, int s);
        cfg_period = W'(p);
        cfg_pulse  = W'(pw);
        cfg_step   = W'(s);
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
    endtask

    task automatic start();
        cfg_enable = 1'b1;
        mon_en     = 1'b1;
        step();
    endtask

    task automatic stop();
        cfg_enable = 1'b0;
        mon_en     = 1'b0;
        step(2);
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            step();
            n++;
        end while (!period_tick && n < 200);
        if (!period_tick) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: no tick within 200 cycles, required one");
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d periods still pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        step(2);
        checks += 4;
        if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b, required 0", pwm_out); end
        if (period_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b, required 0", period_tick); end
        if (cur_pulse !== '0) begin errors++; $display("FAIL reset_cur: got %0d, required 0", cur_pulse); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        ARESETN = 1'b1;
        step(2);
    endtask

    task automatic test_basic();
        update(10, 3, 0);
        cfg_pulse = W'(7);
        push(11, 3);
        push(10, 3);
        push(10, 3);
        start();
        drain();
        checks += 2;
        if (cur_pulse !== W'(3)) begin errors++; $display("FAIL basic_cur: got %0d, required 3", cur_pulse); end
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b, required 0", busy); end
        stop();
    endtask

    task automatic test_double_buffer();
        update(10, 3, 0);
        push(11, 3);
        push(10, 3);
        start();
        wait_tick();
        step(4);
        push(10, 6);
        push(10, 6);
        update(10, 6, 0);
        wait_tick();
        checks++;
        if (cur_pulse !== W'(6)) begin errors++; $display("FAIL dbuf_cur_mid: got %0d, required 6", cur_pulse); end
        wait_tick();
        step(9);
        push(10, 6);
        push(10, 2);
        update(10, 2, 0);
        checks++;
        if (cur_pulse !== W'(6)) begin errors++; $display("FAIL dbuf_cur_late: got %0d, required 6", cur_pulse); end
        drain();
        stop();
    endtask

    task automatic test_ramp();
        update(20, 2, 3);
        push(21, 2);
        push(20, 5);
        push(20, 8);
        start();
        update(20, 9, 3);
        wait_tick();
        checks += 2;
        if (cur_pulse !== W'(5)) begin errors++; $display("FAIL ramp_up1_cur: got %0d, required 5", cur_pulse); end
        if (busy !== 1'b1) begin errors++; $display("FAIL ramp_up1_busy: got %b, required 1", busy); end
        wait_tick();
        checks += 2;
        if (cur_pulse !== W'(8)) begin errors++; $display("FAIL ramp_up2_cur: got %0d, required 8", cur_pulse); end
        if (busy !== 1'b1) begin errors++; $display("FAIL ramp_up2_busy: got %b, required 1", busy); end
        wait_tick();
        checks += 2;
        if (cur_pulse !== W'(9)) begin errors++; $display("FAIL ramp_up3_cur: got %0d, required 9", cur_pulse); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ramp_up3_busy: got %b, required 0", busy); end
        push(20, 9);
        push(20, 6);
        push(20, 3);
        push(20, 1);
        update(20, 1, 3);
        wait_tick();
        checks += 2;
        if (cur_pulse !== W'(6)) begin errors++; $display("FAIL ramp_dn1_cur: got %0d, required 6", cur_pulse); end
        if (busy !== 1'b1) begin errors++; $display("FAIL ramp_dn1_busy: got %b, required 1", busy); end
        drain();
        checks += 2;
        if (cur_pulse !== W'(1)) begin errors++; $display("FAIL ramp_dn_end_cur: got %0d, required 1", cur_pulse); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ramp_dn_end_busy: got %b, required 0", busy); end
        stop();
    endtask

    task automatic test_extremes();
        update(10, 0, 0);
        push(11, 0);
        push(10, 0);
        start();
        drain();
        stop();
        update(10, 15, 0);
        push(11, 10);
        push(10, 10);
        push(10, 10);
        start();
        drain();
        checks++;
        if (cur_pulse !== W'(15)) begin errors++; $display("FAIL full_cur: got %0d, required 15", cur_pulse); end
        stop();
        update(0, 1, 0);
        push(3, 1);
        push(2, 1);
        push(2, 1);
        start();
        drain();
        stop();
    endtask

    task automatic test_disable_reset();
        int ticks = 0;
        update(10, 8, 0);
        push(11, 8);
        start();
        wait_tick();
        step(5);
        cfg_enable = 1'b0;
        mon_en     = 1'b0;
        step();
        checks += 2;
        if (pwm_out !== 1'b0) begin errors++; $display("FAIL disable_pwm: got %b, required 0", pwm_out); end
        if (period_tick !== 1'b0) begin errors++; $display("FAIL disable_tick: got %b, required 0", period_tick); end
        for (int i = 0; i < 15; i++) begin
            step();
            if (period_tick) ticks++;
        end
        checks++;
        if (ticks !== 0) begin errors++; $display("FAIL disable_no_tick: got %0d ticks, required 0", ticks); end
        push(11, 8);
        start();
        wait_tick();
        step(2);
        checks++;
        if (pwm_out !== 1'b1) begin errors++; $display("FAIL pre_reset_pwm: got %b, required 1", pwm_out); end
        ARESETN = 1'b0;
        mon_en  = 1'b0;
        #1;
        checks += 3;
        if (pwm_out !== 1'b0) begin errors++; $display("FAIL async_reset_pwm: got %b, required 0", pwm_out); end
        if (cur_pulse !== '0) begin errors++; $display("FAIL async_reset_cur: got %0d, required 0", cur_pulse); end
        if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b, required 0", busy); end
        cfg_enable = 1'b0;
        step(2);
        ARESETN = 1'b1;
        step(3);
        checks += 3;
        if (pwm_out !== 1'b0) begin errors++; $display("FAIL post_reset_pwm: got %b, required 0", pwm_out); end
        if (period_tick !== 1'b0) begin errors++; $display("FAIL post_reset_tick: got %b, required 0", period_tick); end
        if (cur_pulse !== '0) begin errors++; $display("FAIL post_reset_cur: got %0d, required 0", cur_pulse); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_double_buffer();
        test_ramp();
        test_extremes();
        test_disable_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/pwmservo_core.md
Name: pwmservo_core

Overview:
- PWM generation stage that sits directly downstream of the pwmservo AXI4-Lite register slave.
- Consumes the four slave registers: control/enable, period, target pulse width, and ramp step.
- Produces a servo-style PWM waveform. Configuration is double-buffered so changes apply only on period boundaries.
- Pulse width moves toward the target with an optional per-period slew limit, and a per-period tick output is provided for interrupt/status logic.

Parameters:
- C_CNT_WIDTH, 24, width of the period counter and of all timing values in ACLK cycles (covers 20 ms at 100 MHz).

Ports:
- ACLK  in  1  block clock
- ARESETN  in  1  asynchronous active-low reset
- cfg_enable  in  1  level; reg0 bit0; 1 = generate PWM
- cfg_period  in  C_CNT_WIDTH  reg1; period in cycles
- cfg_pulse  in  C_CNT_WIDTH  reg2; target high time in cycles
- cfg_step  in  C_CNT_WIDTH  reg3; max pulse change per period; 0 = jump immediately
- cfg_update  in  1  one-cycle strobe after any reg1..reg3 write
- pwm_out  out  1  PWM waveform to servo pin
- period_tick  out  1  one-cycle pulse at each period wrap
- cur_pulse  out  C_CNT_WIDTH  pulse width currently applied
- busy  out  1  1 while cur_pulse != active target

Behaviour:
- Reset (async, ARESETN=0): all registers clear to 0 immediately.
  - Cleared state: state=IDLE, counter, pending/active period/pulse/step, cur_pulse, pwm_out, period_tick, busy.
- Pending registers:
  - cfg_update=1 captures cfg_period, cfg_pulse, cfg_step into pending at that clock edge.
  - Without cfg_update, input changes are ignored.
- Period clamp: an active period < 2 is treated as 2.
- States: IDLE, RUN.
- IDLE:
  - counter=0, pwm_out=0, period_tick=0.
  - Active registers track pending registers every cycle, and cur_pulse tracks the active pulse directly (no ramp).
  - cfg_enable=1 → RUN next cycle, counter starts at 0 with the current active values.
- RUN:
  - counter increments each cycle, from 0 to P-1, then wraps to 0.
  - pwm_out is registered: pwm_out(t+1) = (counter(t) < cur_pulse). This is one cycle of latency versus the counter.
- Boundary cycle (counter==P-1):
  - period_tick=1 on the next cycle, for exactly one cycle.
  - Pending values are copied into active for the next period. A cfg_update on that same cycle is captured into pending and applies at the following boundary.
  - cur_pulse is updated against the new active target T with active step S:
    - S==0: cur=T.
    - cur<T: cur = min(cur+S, T).
    - cur>T: cur = max(cur-S, T).
    - Arithmetic uses C_CNT_WIDTH+1 bits; no wrap-around.
  - A new period does not shorten or truncate the current one.
- Disable:
  - cfg_enable=0 in RUN → IDLE next cycle; pwm_out=0 from that cycle.
  - A partial period is abandoned and no period_tick is issued.
- Duty extremes:
  - cur_pulse=0 → pwm_out constant 0.
  - cur_pulse >= P → pwm_out constant 1; period_tick still fires.
- busy = (cur_pulse != active pulse), registered.
- Reset mid-period: outputs drop to 0 asynchronously, and the block restarts in IDLE after deassertion.

Test Plan:
- Reset → all outputs 0.
- Basic waveform:
  - Stimulus: cfg_update with period=10, pulse=3, step=0; then enable=1.
  - Required: pwm_out high 3 cycles, low 7, repeating; period_tick every 10 cycles; cur_pulse=3; busy=0.
- Double buffering:
  - Stimulus: in RUN (period 10, pulse 3), update pulse=6 at counter=4.
  - Required: current period stays 3-high; next period 6-high.
  - Stimulus: update issued exactly at counter=9.
  - Required: takes effect one period later.
- Ramp:
  - Stimulus: from cur_pulse=2, update pulse=9 with step=3, period=20.
  - Required: successive periods show 5, 8, 9; busy=1 until cur_pulse=9.
  - Stimulus: then target 1 with step 3.
  - Required: successive periods show 6, 3, 1.
- Extremes:
  - pulse=0 → pwm_out constant 0.
  - pulse=15 with period=10 → constant 1 with ticks every 10.
  - period=0 → behaves as period 2, tick every 2 cycles.
- Disable/reset:
  - enable=0 at counter=5 → pwm_out 0 next cycle, no tick.
  - Re-enable → counter restarts at 0.
  - ARESETN pulsed low mid-high-phase → pwm_out falls without waiting for a clock edge.
